// File: rtl/ripple_timer_ctrl.sv
// Sequencer for an external ripple counter: clears it, issues spaced ticks with a settle window,
// and compares the settled count to a terminal value. Define RIPPLE_TIMER_CNT_CHECK_EN for count checking.
module ripple_timer_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PS_W   = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] period,
  input  logic [PS_W-1:0]  prescale,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_tick,
  output logic             cnt_clr_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_PRESCALE = 3'd2,
    S_TICK     = 3'd3,
    S_SETTLE   = 3'd4,
    S_CHECK    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_period;
  logic [PS_W-1:0]  r_prescale;
  logic [PS_W-1:0]  r_ps_cnt;
  logic [PS_W-1:0]  w_ps_cnt_next;
  logic [ST_W-1:0]  r_st_cnt;
  logic [ST_W-1:0]  w_st_cnt_next;
  logic             w_accept;
  logic             w_match;
  logic             w_abort;
  logic             w_cnt_bad;

  logic r_cnt_tick;
  logic r_cnt_clr_n;
  logic r_busy;
  logic r_done;
  logic w_tick_next;
  logic w_clr_n_next;
  logic w_busy_next;

  assign w_abort = stop && (r_state != S_IDLE);

`ifdef RIPPLE_TIMER_CNT_CHECK_EN
  logic [WIDTH-1:0] r_exp_cnt;
  logic             r_err;

  assign w_cnt_bad = (r_state == S_CHECK) && (cnt_q != r_exp_cnt);

  // Expected count mirrors what an intact counter should show after each tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_exp_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_exp_cnt <= '0;
    end else if (r_state == S_TICK) begin
      r_exp_cnt <= r_exp_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_cnt_bad && !w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_cnt_bad = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_ps_cnt_next = r_ps_cnt;
    w_st_cnt_next = r_st_cnt;
    w_accept      = 1'b0;
    w_match       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop && (period != '0)) begin
          w_accept     = 1'b1;
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_ps_cnt_next = r_prescale;
        w_state_next  = S_PRESCALE;
      end
      S_PRESCALE: begin
        if (r_ps_cnt == '0) begin
          w_state_next = S_TICK;
        end else begin
          w_ps_cnt_next = r_ps_cnt - PS_ONE;
        end
      end
      S_TICK: begin
        w_st_cnt_next = ST_LOAD;
        w_state_next  = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_st_cnt == '0) begin
          w_state_next = S_CHECK;
        end else begin
          w_st_cnt_next = r_st_cnt - ST_ONE;
        end
      end
      S_CHECK: begin
        // A count mismatch outranks the terminal compare.
        if (w_cnt_bad) begin
          w_state_next = S_IDLE;
        end else if (cnt_q == r_period) begin
          w_match      = 1'b1;
          w_state_next = auto_reload ? S_CLEAR : S_IDLE;
        end else begin
          w_ps_cnt_next = r_prescale;
          w_state_next  = S_PRESCALE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_next = S_IDLE;
      w_match      = 1'b0;
    end
  end

  // Outputs register the decision made in the current state, so they trail the state by one cycle.
  assign w_tick_next  = (r_state == S_TICK) && !w_abort;
  assign w_clr_n_next = !((r_state == S_CLEAR) && !w_abort);
  assign w_busy_next  = (r_state != S_IDLE) && !w_abort && !w_cnt_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ps_cnt    <= '0;
      r_st_cnt    <= '0;
      r_period    <= '0;
      r_prescale  <= '0;
      r_cnt_tick  <= 1'b0;
      r_cnt_clr_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ps_cnt    <= w_ps_cnt_next;
      r_st_cnt    <= w_st_cnt_next;
      r_cnt_tick  <= w_tick_next;
      r_cnt_clr_n <= w_clr_n_next;
      r_busy      <= w_busy_next;
      r_done      <= w_match;
      if (w_accept) begin
        r_period   <= period;
        r_prescale <= prescale;
      end
    end
  end

  assign cnt_tick  = r_cnt_tick;
  assign cnt_clr_n = r_cnt_clr_n;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ripple_timer_ctrl.sv
// Directed bench for ripple_timer_ctrl with a behavioural ripple counter (optionally skipping 1->3).
`timescale 1ns/1ps
module tb_ripple_timer_ctrl;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          auto_reload = 1'b0;
  logic [W-1:0]  period = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  cnt_q = '0;
  logic          cnt_tick;
  logic          cnt_clr_n;
  logic          busy;
  logic          done;
  logic          err;
  logic          skip_en = 1'b0;

  int n_err = 0;
  int n_chk = 0;

  ripple_timer_ctrl #(.WIDTH(W), .PS_W(PW), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .auto_reload(auto_reload),
    .period(period), .prescale(prescale), .cnt_q(cnt_q),
    .cnt_tick(cnt_tick), .cnt_clr_n(cnt_clr_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // External ripple counter: async clear, clocked by the tick pulse.
  always @(posedge cnt_tick or negedge cnt_clr_n) begin
    if (!cnt_clr_n) cnt_q <= '0;
    else if (skip_en && cnt_q == 4'd1) cnt_q <= 4'd3;
    else cnt_q <= cnt_q + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tick", cnt_tick, 0);
    chk("rst_clr_n", cnt_clr_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_clr_n", cnt_clr_n, 1);
    $display("txn reset: released");

    // One-shot, period 3, prescale 0; captured values must survive input changes while busy
    period = 4'd3; prescale = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; period = 4'd9; prescale = 4'd5;
    for (int k = 0; k <= 18; k++) begin
      chk($sformatf("t1_busy_%0d", k), busy, (k >= 1 && k <= 16) ? 1 : 0);
      chk($sformatf("t1_tick_%0d", k), cnt_tick, (k == 3 || k == 8 || k == 13) ? 1 : 0);
      chk($sformatf("t1_done_%0d", k), done, (k == 16) ? 1 : 0);
      chk($sformatf("t1_clr_%0d", k), cnt_clr_n, (k == 1) ? 0 : 1);
      if (k == 16) chk("t1_cnt_at_done", cnt_q, 3);
      @(negedge clk);
    end
    $display("txn one-shot period=3 prescale=0: checked 19 cycles");

    // Auto-reload, period 2, prescale 3
    period = 4'd2; prescale = 4'd3; auto_reload = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      chk($sformatf("t2_busy_%0d", k), busy, (k >= 1) ? 1 : 0);
      chk($sformatf("t2_tick_%0d", k), cnt_tick, (k % 17 == 6 || k % 17 == 14) ? 1 : 0);
      chk($sformatf("t2_done_%0d", k), done, (k > 0 && k % 17 == 0) ? 1 : 0);
      chk($sformatf("t2_clr_%0d", k), cnt_clr_n, (k % 17 == 1) ? 0 : 1);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; auto_reload = 1'b0;
    chk("t2_stop_busy", busy, 0);
    $display("txn auto-reload period=2 prescale=3: checked 41 cycles then stopped");

    // Stop after the 2nd tick of a period-5 run
    period = 4'd5; prescale = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      chk($sformatf("t3_tick_%0d", k), cnt_tick, (k == 3 || k == 8) ? 1 : 0);
      if (k == 9) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    chk("t3_stop_busy", busy, 0);
    chk("t3_stop_done", done, 0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t3_idle_tick_%0d", k), cnt_tick, 0);
      chk($sformatf("t3_idle_done_%0d", k), done, 0);
      chk($sformatf("t3_idle_busy_%0d", k), busy, 0);
      @(negedge clk);
    end
    chk("t3_cnt_kept", cnt_q, 2);
    chk("t3_clr_n", cnt_clr_n, 1);
    start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_ss_busy", busy, 0);
    chk("t3_ss_clr_n", cnt_clr_n, 1);
    start = 1'b0; stop = 1'b0;
    $display("txn stop after tick 2 and start+stop in idle: checked");

    // Reset mid-SETTLE, then period 0 start is ignored
    period = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_tick_before_rst", cnt_tick, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_rst_tick", cnt_tick, 0);
    chk("t4_rst_clr_n", cnt_clr_n, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_rel_clr_n", cnt_clr_n, 1);
    chk("t4_rel_busy", busy, 0);
    period = 4'd0; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t4_p0_busy_%0d", k), busy, 0);
      chk($sformatf("t4_p0_clr_%0d", k), cnt_clr_n, 1);
    end
    start = 1'b0;
    $display("txn reset mid-settle and period=0 start: checked");

    // Faulty counter skipping 1->3 on the 2nd tick, period 5
    skip_en = 1'b1; period = 4'd5; prescale = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
`ifdef RIPPLE_TIMER_CNT_CHECK_EN
    chk("t5_err_set", err, 1);
    chk("t5_err_busy", busy, 0);
    chk("t5_err_done", done, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t5_after_tick_%0d", k), cnt_tick, 0);
      chk($sformatf("t5_after_err_%0d", k), err, 1);
    end
    skip_en = 1'b0; period = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_err_cleared", err, 0);
    repeat (6) @(negedge clk);
    chk("t5_rerun_done", done, 1);
    chk("t5_rerun_err", err, 0);
`else
    chk("t5_noerr", err, 0);
    chk("t5_still_busy", busy, 1);
    repeat (10) @(negedge clk);
    chk("t5_late_done", done, 1);
    chk("t5_late_cnt", cnt_q, 5);
    chk("t5_late_err", err, 0);
`endif
    skip_en = 1'b0;
    $display("txn skipping counter period=5: checked");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ripple_timer_ctrl.md
Name: ripple_timer_ctrl

Overview:
- Sequencer for an external WIDTH-bit ripple counter built from flip-flop primitives.
- Generates the counter's clock pulses (cnt_tick) and clear (cnt_clr_n), and waits a settle window after every tick so the ripple can propagate.
- Compares the settled count to a programmed terminal value and signals completion.
- Supports one-shot and auto-reload timer modes.

Parameters:
WIDTH, 4, counter width; period and cnt_q width
PS_W, 4, prescale field width
SETTLE, 2, idle cycles after each tick before cnt_q is sampled (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low
start  in  1  begin timing run (sampled in IDLE only)
stop  in  1  abort run
auto_reload  in  1  1 = restart after terminal count, 0 = one-shot
period  in  WIDTH  terminal count, captured on accepted start
prescale  in  PS_W  extra wait cycles before each tick, captured on accepted start
cnt_q  in  WIDTH  ripple counter outputs
cnt_tick  out  1  one-cycle pulse clocking the counter
cnt_clr_n  out  1  active-low counter clear
busy  out  1  run in progress
done  out  1  one-cycle pulse at terminal count
err  out  1  sticky count-check error (see Optional Feature)

Behaviour:
- All outputs registered.
- Reset (reset=0 at posedge) overrides everything, including mid-run. Outputs go to: cnt_tick=0, cnt_clr_n=0, busy=0, done=0, err=0. State returns to IDLE.
- First cycle after reset release: cnt_clr_n=1.
- States: IDLE, CLEAR, PRESCALE, TICK, SETTLE, CHECK.
- IDLE:
  - start=1, stop=0 and period!=0: capture period_r and prescale_r, go to CLEAR.
  - period==0: start is ignored.
  - start and stop both high: stay in IDLE.
- CLEAR: cnt_clr_n=0 for exactly 1 cycle, busy=1. Load ps_cnt=prescale_r, then go to PRESCALE.
- PRESCALE:
  - Occupies prescale_r+1 cycles; ps_cnt decrements each cycle.
  - At ps_cnt==0, go to TICK.
- TICK: cnt_tick=1 for exactly 1 cycle. Load st_cnt=SETTLE-1, then go to SETTLE.
- SETTLE: occupies SETTLE cycles, then go to CHECK.
- CHECK (cnt_q sampled here only):
  - cnt_q==period_r: done=1 next cycle. Then go to CLEAR if auto_reload=1 (busy stays 1), else IDLE (busy=0).
  - Otherwise: reload ps_cnt and go to PRESCALE.
- Tick spacing is prescale_r+SETTLE+3 cycles.
- Latency: let E be the edge that accepts start. Tick k's CHECK exits at E+1+k*(prescale_r+SETTLE+3). done is high in the cycle following the final CHECK.
- stop=1 in any busy state: next state IDLE, cnt_tick=0, busy=0, no done.
  - stop has priority over terminal-count detection in CHECK.
  - The counter is not cleared by stop; it is cleared by the next run's CLEAR.
- start while busy is ignored. period/prescale changes while busy are ignored; captured values hold.
- auto_reload is sampled in CHECK, so it may be changed mid-run.
- cnt_q wraps mod 2^WIDTH. Because period_r < 2^WIDTH, a correct counter matches before it wraps.

Optional Feature:
- Macro: RIPPLE_TIMER_CNT_CHECK_EN.
- With macro defined:
  - Internal exp_cnt is cleared in CLEAR and incremented (mod 2^WIDTH) in TICK.
  - In CHECK, cnt_q!=exp_cnt sets err=1, goes to IDLE with busy=0 and no done.
  - err stays set until reset or the next accepted start.
  - Mismatch takes priority over the terminal-count match.
- Without macro: err is tied to 0, exp_cnt is not built, and cnt_q is used only for the terminal compare.

Test Plan:
- period=3, prescale=0, SETTLE=2, auto_reload=0, ideal counter model -> 3 cnt_tick pulses 5 cycles apart; done high one cycle starting E+16; busy 1 from E+1 to E+16 inclusive; cnt_q=3 at done.
- period=2, prescale=3, auto_reload=1 -> ticks 8 cycles apart; done pulses every 17 cycles; cnt_clr_n low one cycle after each done; busy never drops.
- period=5, stop asserted after 2nd tick -> IDLE next edge, busy=0, no done, no further cnt_tick; start+stop together in IDLE -> stays IDLE.
- reset=0 mid-SETTLE -> next edge all outputs at reset values, cnt_clr_n=0; period=0 with start -> no response, busy stays 0.
- (RIPPLE_TIMER_CNT_CHECK_EN) counter model skips from 1 to 3 on 2nd tick, period=5 -> err=1 at 2nd CHECK, busy=0, no done; next start clears err.
